// File: rtl/key_scan_pkg.sv
// Shared constants and row-state encoding for the 4x4 key-matrix scanner.
package key_scan_pkg;

  localparam int unsigned ROWS     = 4;
  localparam int unsigned COLS     = 4;
  localparam logic [15:0] KEY_IDLE = 16'hFFFF;

  typedef enum logic [1:0] {
    S_R0 = 2'd0,
    S_R1 = 2'd1,
    S_R2 = 2'd2,
    S_R3 = 2'd3
  } row_state_e;

  localparam logic [3:0] ROW_DRIVE [ROWS] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

endpackage

// File: rtl/key_col_sync.sv
// Two-flop synchronizer for the raw active-low column lines; resets to all-ones (idle).
module key_col_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_i,
  output logic [3:0] col_o
);

  logic [3:0] s1_q, s1_d;
  logic [3:0] s2_q, s2_d;

  always_comb begin
    s1_d = col_i;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign col_o = s2_q;

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 active-low key-matrix scanner with whole-frame debounce.
// Optional KeyStrobe output (change pulse) is enabled by defining KEY_STROBE_EN.
module key_matrix_scan
  import key_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEBOUNCE_N = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic [7:0] KeyH,
  output logic [7:0] KeyL
`ifdef KEY_STROBE_EN
  ,
  output logic       KeyStrobe
`endif
);

  localparam int unsigned CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned STAB_W = $clog2(DEBOUNCE_N + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_FULL = STAB_W'(DEBOUNCE_N);

  logic [3:0]        col_sync;
  logic              tick;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  row_state_e        state_q, state_d;
  logic [15:0]       raw_q, raw_d;
  logic              frame_done_q, frame_done_d;
  logic [15:0]       cand_q, cand_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [15:0]       key_q, key_d;

  key_col_sync u_col_sync (
    .clk   (Clk),
    .rst   (Rst),
    .col_i (Col),
    .col_o (col_sync)
  );

  always_comb begin
    tick         = (cnt_q == CNT_LAST);
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    state_d      = state_q;
    raw_d        = raw_q;
    frame_done_d = tick && (state_q == S_R3);
    cand_d       = cand_q;
    stab_d       = stab_q;
    key_d        = key_q;

    if (tick) begin
      unique case (state_q)
        S_R0: begin raw_d[3:0]   = col_sync; state_d = S_R1; end
        S_R1: begin raw_d[7:4]   = col_sync; state_d = S_R2; end
        S_R2: begin raw_d[11:8]  = col_sync; state_d = S_R3; end
        S_R3: begin raw_d[15:12] = col_sync; state_d = S_R0; end
      endcase
    end

    // Compare one clock after the frame closes, so raw_q already holds row 3.
    if (frame_done_q) begin
      if (raw_q == cand_q) begin
        if (stab_q != STAB_FULL) stab_d = stab_q + 1'b1;
      end else begin
        cand_d = raw_q;
        stab_d = STAB_W'(1);
      end
      if (stab_d == STAB_FULL) key_d = cand_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q        <= '0;
      state_q      <= S_R0;
      raw_q        <= KEY_IDLE;
      frame_done_q <= 1'b0;
      cand_q       <= KEY_IDLE;
      stab_q       <= '0;
      key_q        <= KEY_IDLE;
    end else begin
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      raw_q        <= raw_d;
      frame_done_q <= frame_done_d;
      cand_q       <= cand_d;
      stab_q       <= stab_d;
      key_q        <= key_d;
    end
  end

  assign Row  = ROW_DRIVE[state_q];
  assign KeyH = key_q[15:8];
  assign KeyL = key_q[7:0];

`ifdef KEY_STROBE_EN
  logic strobe_q, strobe_d;

  always_comb begin
    strobe_d = (key_d != key_q);
  end

  always_ff @(posedge Clk) begin
    if (Rst) strobe_q <= 1'b0;
    else     strobe_q <= strobe_d;
  end

  assign KeyStrobe = strobe_q;
`endif

endmodule
